vend_order_initiator: RTL
=========================

# vend_order_initiator

Sequential front end that drives the combinational `vendingmachine` purchase evaluator from the initiator side. It accumulates inserted coins into a credit register and latches a product selection. It then presents `code`/`count`/`money` to the evaluator for one cycle, samples `posibility`/`remaining`, and pays out change one unit per cycle. It sits between the coin/keypad logic and the evaluator.

## Interface
- `MONEY_W`, default 4: credit, money and change width.
- `MAX_CREDIT`, default 15: highest credit value accepted.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `coin_valid` in 1: coin insert strobe, one cycle per coin.
- `coin_value` in MONEY_W: value of the inserted coin in units.
- `sel_valid` in 1: purchase request strobe.
- `sel_code` in 2: product code.
- `sel_count` in 3: item quantity.
- `cancel` in 1: refund request.
- `code` out 2: request code to the evaluator.
- `count` out 3: request count to the evaluator.
- `money` out MONEY_W: request money to the evaluator.
- `posibility` in 1: evaluator verdict, combinational from `code`/`count`/`money`.
- `remaining` in MONEY_W: evaluator change amount.
- `vend_ok` out 1: one-cycle pulse, purchase accepted.
- `vend_fail` out 1: one-cycle pulse, purchase refused.
- `coin_reject` out 1: one-cycle pulse, coin not credited.
- `change_pulse` out 1: one unit of change paid per high cycle.
- `credit` out MONEY_W: current credit.
- `busy` out 1: high whenever state ≠ IDLE.

## Operation
- States: IDLE, REQ, DISPENSE.
- **IDLE, coin:** if `credit + coin_value <= MAX_CREDIT`, add the coin to credit. Otherwise credit is unchanged and `coin_reject` pulses. The sum is computed at MONEY_W+1 bits, with no wrap.
- **IDLE, priority:** `cancel` > `sel_valid` > `coin_valid`. A coin arriving in the same cycle as `cancel` or `sel_valid` is rejected.
- **IDLE, cancel:** if credit > 0, load the change counter with credit, clear credit, go to DISPENSE. If credit = 0, `cancel` is ignored.
- **IDLE, selection:** if `sel_count != 0`, latch `sel_code`/`sel_count` into `code`/`count` and go to REQ. If `sel_count == 0`, `vend_fail` pulses and the state stays IDLE.
- **REQ (exactly one cycle):** `money` equals credit. `posibility`/`remaining` are sampled at the closing edge.
  - `posibility = 1`: `vend_ok` pulses and credit clears. The change counter loads `min(remaining, credit)`. Go to DISPENSE if that value > 0, else IDLE.
  - `posibility = 0`: `vend_fail` pulses, credit is kept, go to IDLE.
- **DISPENSE:** `change_pulse` is high every cycle while counter > 0, and the counter decrements. Return to IDLE when the counter reaches 0. `cancel`, `sel_valid` and `coin_valid` are ignored here; coins get `coin_reject`.
- **Outside IDLE:** `cancel` is ignored, and coins are rejected.
- `money` always mirrors credit. `code`/`count` hold their last latched values.

## Timing
- Reset values: state IDLE, credit 0, counter 0, `code` 0, `count` 0. All outputs 0, including `money`, the pulses and `busy`.
- **Coin:** coin at edge t gives credit updated after edge t. A reject gives `coin_reject` high in cycle t+1.
- **Purchase:** `sel_valid` sampled at edge t puts REQ in cycle t+1. `vend_ok`/`vend_fail` is high in cycle t+2.
  - The first `change_pulse` is also in cycle t+2; change N occupies cycles t+2 … t+1+N.
  - `busy` is back low in cycle t+2+N.
- **Cancel:** at edge t, `change_pulse` is high in cycles t+1 … t+credit.
- All outputs are registered except `busy`, which is decoded from state. `code`/`count`/`money` are stable for the whole REQ cycle.
- **Async reset** mid-DISPENSE aborts payout immediately; the unpaid units are lost. Reset mid-REQ produces no `vend_ok`/`vend_fail` pulse.

## Structure
- Package `vend_pkg`:
  - state enum `vend_state_t` (IDLE, REQ, DISPENSE);
  - `MONEY_W`, `MAX_CREDIT`;
  - `CODE_W=2`, `COUNT_W=3`.
- Sub-module `vend_change_counter`: loadable MONEY_W down-counter with `load`, `load_val`, `busy` and a `pulse` output.
- Evaluator: the bench instantiates the existing `vendingmachine` as the responder.

## Test plan
- **Coins:** reset, then coins 5, 5, 4 → `credit` 14. Then coin 2 → `coin_reject` pulse, credit stays 14.
- **Successful purchase:** credit 15, `sel_code=1`, `sel_count=1` → REQ drives 1/1/15. Response: `vend_ok` at t+2, exactly `remaining` `change_pulse` cycles, credit 0, `busy` low afterward.
- **Refused purchase:** credit 1, selection priced above credit → `vend_fail` at t+2, credit stays 1, no `change_pulse`.
- **Cancel:** credit 7, `cancel` → 7 consecutive `change_pulse` cycles. A `cancel` or `sel_valid` issued during DISPENSE is ignored.
- **Simultaneous events:** `sel_valid` and `coin_valid` in the same cycle → coin rejected, request uses the old credit. `sel_count=0` → `vend_fail`, state stays IDLE.
- **Reset mid-dispense:** assert `rst_n` low during DISPENSE → all outputs 0 asynchronously, state IDLE, no further pulses.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared types and defaults for the vending order initiator.
package vend_pkg;

  localparam int unsigned MONEY_W    = 4;
  localparam int unsigned MAX_CREDIT = 15;
  localparam int unsigned CODE_W     = 2;
  localparam int unsigned COUNT_W    = 3;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    DISPENSE = 2'd2
  } vend_state_t;

endpackage

// File: rtl/vend_change_counter.sv
// Loadable change down-counter: one pulse per unit while non-zero.
module vend_change_counter #(
  parameter int unsigned MONEY_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [MONEY_W-1:0] load_val,
  output logic               busy,
  output logic               last,
  output logic               pulse
);

  logic [MONEY_W-1:0] cnt_q, cnt_d;
  logic               pulse_q, pulse_d;

  // Next count: load wins, otherwise decrement towards zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - MONEY_W'(1);
    end
    pulse_d = (cnt_d != '0);
  end

  // Counter and registered pulse; reset drops any unpaid units.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign busy  = (cnt_q != '0);
  assign last  = (cnt_q == MONEY_W'(1));
  assign pulse = pulse_q;

endmodule

// File: rtl/vend_order_initiator.sv
// Credit accumulation, purchase request sequencing and change payout
// in front of the combinational vendingmachine evaluator.
module vend_order_initiator #(
  parameter int unsigned MONEY_W    = vend_pkg::MONEY_W,
  parameter int unsigned MAX_CREDIT = vend_pkg::MAX_CREDIT
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         coin_valid,
  input  logic [MONEY_W-1:0]           coin_value,
  input  logic                         sel_valid,
  input  logic [vend_pkg::CODE_W-1:0]  sel_code,
  input  logic [vend_pkg::COUNT_W-1:0] sel_count,
  input  logic                         cancel,
  output logic [vend_pkg::CODE_W-1:0]  code,
  output logic [vend_pkg::COUNT_W-1:0] count,
  output logic [MONEY_W-1:0]           money,
  input  logic                         posibility,
  input  logic [MONEY_W-1:0]           remaining,
  output logic                         vend_ok,
  output logic                         vend_fail,
  output logic                         coin_reject,
  output logic                         change_pulse,
  output logic [MONEY_W-1:0]           credit,
  output logic                         busy
);

  import vend_pkg::*;

  localparam logic [MONEY_W:0] MAX_SUM = (MONEY_W+1)'(MAX_CREDIT);

  vend_state_t          state_q;
  logic [MONEY_W-1:0]   credit_q;
  logic [CODE_W-1:0]    code_q;
  logic [COUNT_W-1:0]   count_q;
  logic                 vend_ok_q, vend_fail_q, coin_reject_q;

  logic [MONEY_W:0]     coin_sum;
  logic                 coin_fits;
  logic [MONEY_W-1:0]   req_change;
  logic                 cnt_load;
  logic [MONEY_W-1:0]   cnt_load_val;
  logic                 cnt_busy, cnt_last, cnt_pulse;

  // Coin sum at one extra bit, change clamp and counter load decode.
  always_comb begin
    coin_sum     = {1'b0, credit_q} + {1'b0, coin_value};
    coin_fits    = (coin_sum <= MAX_SUM);
    req_change   = (remaining < credit_q) ? remaining : credit_q;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    unique case (state_q)
      IDLE: begin
        if (cancel && (credit_q != '0)) begin
          cnt_load     = 1'b1;
          cnt_load_val = credit_q;
        end
      end
      REQ: begin
        if (posibility && (req_change != '0)) begin
          cnt_load     = 1'b1;
          cnt_load_val = req_change;
        end
      end
      default: ;
    endcase
  end

  // Main FSM with registered credit, request fields and status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      credit_q      <= '0;
      code_q        <= '0;
      count_q       <= '0;
      vend_ok_q     <= 1'b0;
      vend_fail_q   <= 1'b0;
      coin_reject_q <= 1'b0;
    end else begin
      vend_ok_q     <= 1'b0;
      vend_fail_q   <= 1'b0;
      coin_reject_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          // cancel > selection > coin; a coin losing arbitration is rejected
          if (cancel) begin
            coin_reject_q <= coin_valid;
            if (credit_q != '0) begin
              credit_q <= '0;
              state_q  <= DISPENSE;
            end
          end else if (sel_valid) begin
            coin_reject_q <= coin_valid;
            if (sel_count != '0) begin
              code_q  <= sel_code;
              count_q <= sel_count;
              state_q <= REQ;
            end else begin
              vend_fail_q <= 1'b1;
            end
          end else if (coin_valid) begin
            if (coin_fits) begin
              credit_q <= coin_sum[MONEY_W-1:0];
            end else begin
              coin_reject_q <= 1'b1;
            end
          end
        end
        REQ: begin
          coin_reject_q <= coin_valid;
          if (posibility) begin
            vend_ok_q <= 1'b1;
            credit_q  <= '0;
            state_q   <= (req_change != '0) ? DISPENSE : IDLE;
          end else begin
            vend_fail_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        DISPENSE: begin
          coin_reject_q <= coin_valid;
          if (cnt_last) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  vend_change_counter #(
    .MONEY_W (MONEY_W)
  ) u_change (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .busy     (cnt_busy),
    .last     (cnt_last),
    .pulse    (cnt_pulse)
  );

  assign code         = code_q;
  assign count        = count_q;
  assign money        = credit_q;
  assign credit       = credit_q;
  assign vend_ok      = vend_ok_q;
  assign vend_fail    = vend_fail_q;
  assign coin_reject  = coin_reject_q;
  assign change_pulse = cnt_pulse;
  assign busy         = (state_q != IDLE);

  // Counter activity is implied by the DISPENSE state.
  logic unused_cnt_busy;
  assign unused_cnt_busy = cnt_busy;

endmodule
